dmem_store_buffer: RTL and testbench

- Responder side of the datapath's memory-stage data interface.
- Accepts word stores and reads from the MEM stage and holds stores in a coalescing write buffer.
- Drains the buffer into a single-write-port word RAM.
- Serves reads combinationally, with forwarding from the buffer; drives a stall when a store cannot be accepted.

---
 rtl/dmem_store_buffer.sv | 99 +++++++++
 tb/tb_dmem_store_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// Memory-stage data responder: coalescing FIFO write buffer in front of a
// single-write-port word RAM, with combinational read forwarding and store stall.
module dmem_store_buffer #(
   parameter int DEPTH_WORDS = 256,
   parameter int WB_DEPTH    = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      MemWrite_M,
   input  logic [31:0]               ALUResult_M,
   input  logic [31:0]               WriteData_M,
   output logic [31:0]               ReadData_M,
   output logic                      Stall_M,
   output logic                      MisalignErr,
   output logic [$clog2(WB_DEPTH):0] WBCount
);
   localparam int IDX = $clog2(DEPTH_WORDS);
   localparam int PW  = $clog2(WB_DEPTH);
   localparam int CW  = PW + 1;

   logic [31:0]    mem       [DEPTH_WORDS];
   logic [IDX-1:0] wb_idx_q  [WB_DEPTH];
   logic [31:0]    wb_data_q [WB_DEPTH];

   logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           err_q, err_d;

   logic [IDX-1:0] idx;
   logic           hit;
   logic [PW-1:0]  hit_pos;
   logic [PW-1:0]  off;
   logic           st_ok, full, push, coal, drain;
   logic           unused_addr;

   assign idx         = ALUResult_M[IDX+1:2];
   assign unused_addr = ^ALUResult_M[31:IDX+2];

   // An entry is live when its distance from head is below the occupancy.
   always_comb begin
      hit     = 1'b0;
      hit_pos = '0;
      off     = '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         off = PW'(i) - head_q;
         if ({1'b0, off} < cnt_q && wb_idx_q[i] == idx) begin
            hit     = 1'b1;
            hit_pos = PW'(i);
         end
      end
   end

   assign ReadData_M = hit ? wb_data_q[hit_pos] : mem[idx];

   assign st_ok   = MemWrite_M && (ALUResult_M[1:0] == 2'b00);
   assign full    = (cnt_q == CW'(WB_DEPTH));
   assign coal    = st_ok && hit;
   assign push    = st_ok && !hit && !full;
   assign Stall_M = st_ok && !hit && full;
   // Drain only in cycles with no accepted store, so pops never race a push or coalesce.
   assign drain   = (cnt_q != '0) && (!MemWrite_M || Stall_M);

   always_comb begin
      head_d = head_q + PW'(drain);
      tail_d = tail_q + PW'(push);
      cnt_d  = cnt_q + CW'(push) - CW'(drain);
      err_d  = err_q | (MemWrite_M && (ALUResult_M[1:0] != 2'b00));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   // Entry storage needs no reset: liveness comes from head/count.
   always_ff @(posedge clk) begin
      if (push) begin
         wb_idx_q[tail_q]  <= idx;
         wb_data_q[tail_q] <= WriteData_M;
      end
      if (coal) wb_data_q[hit_pos] <= WriteData_M;
   end

   always_ff @(posedge clk) begin
      if (drain) mem[wb_idx_q[head_q]] <= wb_data_q[head_q];
   end

   assign MisalignErr = err_q;
   assign WBCount     = cnt_q;
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: directed vector table, reset/corner sequences,
// and random traffic checked against a queue-based reference model.
module tb_dmem_store_buffer;
   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite_M;
   logic [31:0] ALUResult_M, WriteData_M, ReadData_M;
   logic        Stall_M, MisalignErr;
   logic [2:0]  WBCount;

   always #5 clk = ~clk;

   dmem_store_buffer #(.DEPTH_WORDS(256), .WB_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .MemWrite_M(MemWrite_M), .ALUResult_M(ALUResult_M),
      .WriteData_M(WriteData_M), .ReadData_M(ReadData_M), .Stall_M(Stall_M),
      .MisalignErr(MisalignErr), .WBCount(WBCount)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: RAM image with known flags, FIFO of pending {index,data}.
   logic [31:0] mref [256];
   bit          mknown [256];
   int          q_idx [$];
   logic [31:0] q_dat [$];
   bit          merr;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] rd;
      bit          stall;
      int          cnt;
      bit          err;
   } vec_t;
   vec_t vt [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic int m_find(input int i);
      for (int k = 0; k < q_idx.size(); k++) if (q_idx[k] == i) return k;
      return -1;
   endfunction

   function automatic bit m_stall(input bit we, input logic [31:0] a);
      return we && a[1:0] == 2'b00 && m_find(int'(a[9:2])) < 0 && q_idx.size() == 4;
   endfunction

   function automatic void m_drain();
      mref[q_idx[0]]   = q_dat[0];
      mknown[q_idx[0]] = 1'b1;
      void'(q_idx.pop_front());
      void'(q_dat.pop_front());
   endfunction

   function automatic void m_step(input bit we, input logic [31:0] a, input logic [31:0] d);
      int i, p;
      i = int'(a[9:2]);
      if (!we) begin
         if (q_idx.size() > 0) m_drain();
      end else if (a[1:0] != 2'b00) begin
         merr = 1'b1;
      end else begin
         p = m_find(i);
         if (p >= 0) q_dat[p] = d;
         else if (q_idx.size() < 4) begin
            q_idx.push_back(i);
            q_dat.push_back(d);
         end else m_drain();
      end
   endfunction

   function automatic void m_reset();
      q_idx.delete();
      q_dat.delete();
      merr = 1'b0;
   endfunction

   // One clock: drive, check combinational outputs, take the edge, check state.
   task automatic cyc(input bit we, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output bit st, output int c, output bit e);
      int i, p;
      MemWrite_M  = we;
      ALUResult_M = a;
      WriteData_M = d;
      #2;
      i = int'(a[9:2]);
      p = m_find(i);
      rd = ReadData_M;
      st = Stall_M;
      if (p >= 0) chk("rd_fwd", ReadData_M, q_dat[p]);
      else if (mknown[i]) chk("rd_ram", ReadData_M, mref[i]);
      chk("stall", {31'b0, Stall_M}, {31'b0, m_stall(we, a)});
      @(posedge clk);
      m_step(we, a, d);
      #1;
      c = int'(WBCount);
      e = MisalignErr;
      chk("wbcount", {29'b0, WBCount}, 32'(q_idx.size()));
      chk("misalign", {31'b0, MisalignErr}, {31'b0, merr});
   endtask

   task automatic rst_pulse();
      MemWrite_M = 1'b0;
      reset = 1'b0;
      #1;
      m_reset();
      chk("rst_cnt", {29'b0, WBCount}, 32'd0);
      chk("rst_err", {31'b0, MisalignErr}, 32'd0);
      chk("rst_stall", {31'b0, Stall_M}, 32'd0);
      #1 reset = 1'b1;
   endtask

   function automatic void add(input bit we, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] rd, input bit st, input int c, input bit e);
      vec_t v;
      v.we = we; v.addr = a; v.data = d; v.rd = rd; v.stall = st; v.cnt = c; v.err = e;
      vt.push_back(v);
   endfunction

   initial begin
      logic [31:0] rd;
      bit st, e;
      int c;

      // RAM image after the fill loop below is C0DE0000+index.
      add(1, 32'h010, 32'hDEADBEEF, 32'hC0DE0004, 0, 1, 0);
      add(0, 32'h010, 32'h0,        32'hDEADBEEF, 0, 0, 0);
      add(0, 32'h010, 32'h0,        32'hDEADBEEF, 0, 0, 0);
      add(1, 32'h000, 32'h1,        32'hC0DE0000, 0, 1, 0);
      add(1, 32'h004, 32'h2,        32'hC0DE0001, 0, 2, 0);
      add(1, 32'h008, 32'h3,        32'hC0DE0002, 0, 3, 0);
      add(1, 32'h00C, 32'h4,        32'hC0DE0003, 0, 4, 0);
      add(1, 32'h020, 32'h5,        32'hC0DE0008, 1, 3, 0);
      add(1, 32'h020, 32'h5,        32'hC0DE0008, 0, 4, 0);
      add(1, 32'h008, 32'h33,       32'h3,        0, 4, 0);
      add(0, 32'h008, 32'h0,        32'h33,       0, 3, 0);
      add(0, 32'h000, 32'h0,        32'h1,        0, 2, 0);
      add(0, 32'h004, 32'h0,        32'h2,        0, 1, 0);
      add(0, 32'h008, 32'h0,        32'h33,       0, 0, 0);
      add(0, 32'h020, 32'h0,        32'h5,        0, 0, 0);
      add(1, 32'h040, 32'h1,        32'hC0DE0010, 0, 1, 0);
      add(1, 32'h040, 32'h2,        32'h1,        0, 1, 0);
      add(1, 32'h042, 32'h7,        32'h2,        0, 1, 1);
      add(1, 32'h044, 32'h8,        32'hC0DE0011, 0, 2, 1);
      add(0, 32'h040, 32'h0,        32'h2,        0, 1, 1);
      add(0, 32'h044, 32'h0,        32'h8,        0, 0, 1);
      add(1, 32'h400, 32'hA5A5A5A5, 32'h1,        0, 1, 1);
      add(0, 32'h000, 32'h0,        32'hA5A5A5A5, 0, 0, 1);
      add(0, 32'h400, 32'h0,        32'hA5A5A5A5, 0, 0, 1);

      for (int k = 0; k < 256; k++) mknown[k] = 1'b0;
      m_reset();
      MemWrite_M = 1'b0; ALUResult_M = '0; WriteData_M = '0;
      reset = 1'b0;
      #1;
      chk("init_cnt", {29'b0, WBCount}, 32'd0);
      chk("init_err", {31'b0, MisalignErr}, 32'd0);
      chk("init_stall", {31'b0, Stall_M}, 32'd0);
      #11 reset = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < 256; k++) begin
         cyc(1'b1, 32'(k * 4), 32'hC0DE0000 + 32'(k), rd, st, c, e);
         cyc(1'b0, 32'(k * 4), 32'h0, rd, st, c, e);
      end

      for (int k = 0; k < vt.size(); k++) begin
         cyc(vt[k].we, vt[k].addr, vt[k].data, rd, st, c, e);
         chk($sformatf("vec%0d_rd", k), rd, vt[k].rd);
         chk($sformatf("vec%0d_stall", k), {31'b0, st}, {31'b0, vt[k].stall});
         chk($sformatf("vec%0d_cnt", k), 32'(c), 32'(vt[k].cnt));
         chk($sformatf("vec%0d_err", k), {31'b0, e}, {31'b0, vt[k].err});
      end

      // Reset with three stores pending: they are lost and RAM keeps old contents.
      cyc(1'b1, 32'h100, 32'h11111111, rd, st, c, e);
      cyc(1'b1, 32'h104, 32'h22222222, rd, st, c, e);
      cyc(1'b1, 32'h108, 32'h33333333, rd, st, c, e);
      chk("pend_cnt", 32'(c), 32'd3);
      rst_pulse();
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 32'h100 + 32'(k * 4), 32'h0, rd, st, c, e);
         chk($sformatf("post_rst_rd%0d", k), rd, 32'hC0DE0040 + 32'(k));
         chk($sformatf("post_rst_err%0d", k), {31'b0, e}, 32'd0);
      end

      for (int n = 0; n < 3000; n++) begin
         bit we;
         logic [31:0] a;
         we = ($urandom_range(0, 9) < 7);
         a  = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 11) * 4);
         if ($urandom_range(0, 15) == 0) a[1:0] = 2'($urandom_range(1, 3));
         cyc(we, a, $urandom, rd, st, c, e);
         if ($urandom_range(0, 299) == 0) rst_pulse();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
